mem_store_buffer: RTL and testbench

- Write-coalescing store buffer between the CPU core's store port and the memory core bus.
- Accepts 32-bit word stores and merges consecutive stores to the same 16-byte line into one entry.
- Drains entries in order as line-write requests with byte masks, one line per memory handshake.
- Flags loads that hit a pending line so the core stalls them; the core checks `empty` before offload.

---
 rtl/mem_store_buffer_if.sv | 37 +++
 rtl/mem_store_buffer.sv | 154 +++++++++++++++
 tb/tb_mem_store_buffer.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_store_buffer_if.sv
// Store port, memory line-write port and load-probe signals of the store buffer.
// The buffer itself uses the slave modport; the core/memory side uses master.
interface mem_store_buffer_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int WORD_WIDTH = 32,
    parameter int LINE_WIDTH = 128
);
    logic                    st_valid;
    logic                    st_ready;
    logic [ADDR_WIDTH-1:0]   st_addr;
    logic [WORD_WIDTH-1:0]   st_data;

    logic                    mem_req_valid;
    logic                    mem_req_ready;
    logic [ADDR_WIDTH-1:0]   mem_req_addr;
    logic [LINE_WIDTH-1:0]   mem_req_data;
    logic [LINE_WIDTH/8-1:0] mem_req_mask;

    logic [ADDR_WIDTH-1:0]   ld_addr;
    logic                    ld_hit;
    logic                    ld_fwd_valid;
    logic [WORD_WIDTH-1:0]   ld_fwd_data;

    logic                    empty;

    modport slave (
        input  st_valid, st_addr, st_data, mem_req_ready, ld_addr,
        output st_ready, mem_req_valid, mem_req_addr, mem_req_data, mem_req_mask,
        output ld_hit, ld_fwd_valid, ld_fwd_data, empty
    );

    modport master (
        output st_valid, st_addr, st_data, mem_req_ready, ld_addr,
        input  st_ready, mem_req_valid, mem_req_addr, mem_req_data, mem_req_mask,
        input  ld_hit, ld_fwd_valid, ld_fwd_data, empty
    );
endinterface

// File: rtl/mem_store_buffer.sv
// Write-coalescing store buffer: merges word stores into line entries and drains them in order.
// Define STORE_BUFFER_FORWARD_EN to forward fully-written words to hitting loads.
module mem_store_buffer #(
    parameter int ADDR_WIDTH = 32,
    parameter int WORD_WIDTH = 32,
    parameter int LINE_WIDTH = 128,
    parameter int DEPTH      = 4
) (
    input  logic              clock,
    input  logic              reset,
    mem_store_buffer_if.slave bus
);
    localparam int LINE_BYTES = LINE_WIDTH / 8;
    localparam int WORD_BYTES = WORD_WIDTH / 8;
    localparam int WORDS      = LINE_WIDTH / WORD_WIDTH;
    localparam int OFF_W      = $clog2(LINE_BYTES);
    localparam int BYTE_W     = $clog2(WORD_BYTES);
    localparam int SEL_W      = $clog2(WORDS);
    localparam int TAG_W      = ADDR_WIDTH - OFF_W;
    localparam int PTR_W      = $clog2(DEPTH);
    localparam int CNT_W      = PTR_W + 1;

    logic [TAG_W-1:0]      tag_reg  [DEPTH];
    logic [LINE_WIDTH-1:0] data_reg [DEPTH];
    logic [LINE_BYTES-1:0] mask_reg [DEPTH];

    logic [PTR_W-1:0]      head_reg;
    logic [PTR_W-1:0]      tail_reg;
    logic [PTR_W-1:0]      newest;
    logic [CNT_W-1:0]      count_reg;
    logic [CNT_W-1:0]      count_next;
    logic                  empty_reg;

    logic [TAG_W-1:0]      st_tag;
    logic [TAG_W-1:0]      ld_tag;
    logic [SEL_W-1:0]      st_sel;
    logic [WORDS-1:0]      st_slot;
    logic [LINE_WIDTH-1:0] fill_data;
    logic [LINE_WIDTH-1:0] fill_bits;
    logic [LINE_BYTES-1:0] fill_mask;
    logic                  accept;
    logic                  pop;
    logic                  merge;
    logic                  alloc;
    logic [DEPTH-1:0]      line_match;

    assign st_tag = bus.st_addr[ADDR_WIDTH-1:OFF_W];
    assign st_sel = bus.st_addr[OFF_W-1:BYTE_W];
    assign ld_tag = bus.ld_addr[ADDR_WIDTH-1:OFF_W];
    assign newest = tail_reg - PTR_W'(1);

    genvar gi;
    generate
        // Line-wide image of the incoming word: data in its slot, zeros elsewhere.
        for (gi = 0; gi < WORDS; gi++) begin : g_slot
            assign st_slot[gi] = (st_sel == SEL_W'(gi));
            assign fill_data[gi*WORD_WIDTH +: WORD_WIDTH] = st_slot[gi] ? bus.st_data : '0;
            assign fill_bits[gi*WORD_WIDTH +: WORD_WIDTH] = {WORD_WIDTH{st_slot[gi]}};
            assign fill_mask[gi*WORD_BYTES +: WORD_BYTES] = {WORD_BYTES{st_slot[gi]}};
        end
    endgenerate

    assign bus.st_ready = reset && (count_reg != CNT_W'(DEPTH));
    assign accept       = bus.st_valid && bus.st_ready;
    assign pop          = bus.mem_req_valid && bus.mem_req_ready;
    // Requiring two entries keeps the presented head out of reach of a merge.
    assign merge        = accept && (count_reg >= CNT_W'(2)) && (tag_reg[newest] == st_tag);
    assign alloc        = accept && !merge;
    assign count_next   = count_reg + CNT_W'(alloc) - CNT_W'(pop);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
            empty_reg <= 1'b1;
        end else begin
            if (alloc) tail_reg <= tail_reg + PTR_W'(1);
            if (pop)   head_reg <= head_reg + PTR_W'(1);
            count_reg <= count_next;
            empty_reg <= (count_next == '0);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                tag_reg[i]  <= '0;
                data_reg[i] <= '0;
                mask_reg[i] <= '0;
            end
        end else if (alloc) begin
            tag_reg[tail_reg]  <= st_tag;
            data_reg[tail_reg] <= fill_data;
            mask_reg[tail_reg] <= fill_mask;
        end else if (merge) begin
            data_reg[newest] <= (data_reg[newest] & ~fill_bits) | fill_data;
            mask_reg[newest] <= mask_reg[newest] | fill_mask;
        end
    end

    assign bus.mem_req_valid = (count_reg != '0);
    assign bus.mem_req_addr  = {tag_reg[head_reg], {OFF_W{1'b0}}};
    assign bus.mem_req_data  = data_reg[head_reg];
    assign bus.mem_req_mask  = mask_reg[head_reg];
    assign bus.empty         = empty_reg;

    generate
        // An entry is live when its distance from the head is below the count.
        for (gi = 0; gi < DEPTH; gi++) begin : g_match
            logic [PTR_W-1:0] age;
            assign age = PTR_W'(gi) - head_reg;
            assign line_match[gi] = ({1'b0, age} < count_reg) && (tag_reg[gi] == ld_tag);
        end
    endgenerate

    assign bus.ld_hit = |line_match;

`ifdef STORE_BUFFER_FORWARD_EN
    logic [SEL_W-1:0]      ld_sel;
    logic                  fwd_found;
    logic [PTR_W-1:0]      fwd_idx;
    logic [PTR_W-1:0]      scan_idx;
    logic [WORD_BYTES-1:0] fwd_mask;
    logic                  unused_bits;

    assign ld_sel = bus.ld_addr[OFF_W-1:BYTE_W];

    // Only the youngest matching entry may forward; older copies are stale.
    always_comb begin
        fwd_found = 1'b0;
        fwd_idx   = '0;
        scan_idx  = '0;
        for (int j = 0; j < DEPTH; j++) begin
            scan_idx = newest - PTR_W'(j);
            if (!fwd_found && line_match[scan_idx]) begin
                fwd_found = 1'b1;
                fwd_idx   = scan_idx;
            end
        end
    end

    assign fwd_mask         = mask_reg[fwd_idx][ld_sel*WORD_BYTES +: WORD_BYTES];
    assign bus.ld_fwd_valid = fwd_found && (&fwd_mask);
    assign bus.ld_fwd_data  = bus.ld_fwd_valid ? data_reg[fwd_idx][ld_sel*WORD_WIDTH +: WORD_WIDTH] : '0;
    assign unused_bits      = ^{bus.st_addr[BYTE_W-1:0], bus.ld_addr[BYTE_W-1:0]};
`else
    logic unused_bits;

    assign bus.ld_fwd_valid = 1'b0;
    assign bus.ld_fwd_data  = '0;
    assign unused_bits      = ^{bus.st_addr[BYTE_W-1:0], bus.ld_addr[OFF_W-1:0]};
`endif
endmodule

// File: tb/tb_mem_store_buffer.sv
// Bench for mem_store_buffer: directed scenarios plus a randomized run against a line-queue model.
module tb_mem_store_buffer;
    localparam int AW = 32, WW = 32, LW = 128, DEPTH = 4;
`ifdef STORE_BUFFER_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct packed {
        logic [27:0]  line;
        logic [127:0] data;
        logic [15:0]  mask;
    } line_t;

    logic  clock = 1'b0;
    logic  reset = 1'b0;
    line_t model_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    always #5 clock = ~clock;

    mem_store_buffer_if #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .LINE_WIDTH(LW)) bus ();

    mem_store_buffer #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .LINE_WIDTH(LW), .DEPTH(DEPTH)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    // Advance one clock from a negedge; the model applies the spec's accept/merge/pop rules.
    task automatic cycle();
        logic acc, pp;
        logic [27:0] ln;
        logic [31:0] d;
        int k;
        line_t e;
        #1;
        acc = bus.st_valid && reset && (model_q.size() < DEPTH);
        pp  = bus.mem_req_ready && reset && (model_q.size() > 0);
        ln  = bus.st_addr[31:4];
        k   = int'(bus.st_addr[3:2]);
        d   = bus.st_data;
        @(posedge clock);
        if (acc) begin
            if (model_q.size() >= 2 && model_q[model_q.size()-1].line == ln) begin
                e = model_q[model_q.size()-1];
                e.data[32*k +: 32] = d;
                e.mask[4*k +: 4]   = 4'hF;
                model_q[model_q.size()-1] = e;
            end else begin
                e = '0;
                e.line = ln;
                e.data[32*k +: 32] = d;
                e.mask[4*k +: 4]   = 4'hF;
                model_q.push_back(e);
            end
        end
        if (pp) void'(model_q.pop_front());
        @(negedge clock);
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d);
        int waited = 0;
        bus.st_valid = 1'b1;
        bus.st_addr  = a;
        bus.st_data  = d;
        #1;
        while (!bus.st_ready && waited < 20) begin
            cycle();
            waited++;
        end
        n_checks++;
        if (bus.st_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL store_wait addr=%h: st_ready=%b, required 1", a, bus.st_ready);
        end
        cycle();
        bus.st_valid = 1'b0;
    endtask

    task automatic drain();
        int waited = 0;
        bus.mem_req_ready = 1'b1;
        #1;
        while (bus.mem_req_valid && waited < 20) begin
            cycle();
            waited++;
        end
        n_checks++;
        if (bus.empty !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_timeout: empty=%b, required 1", bus.empty);
        end
        bus.mem_req_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        n_checks++; if (bus.st_ready !== 1'b0) begin n_fail++; $display("FAIL rst_st_ready: got %b want 0", bus.st_ready); end
        n_checks++; if (bus.mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_req_valid: got %b want 0", bus.mem_req_valid); end
        n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL rst_empty: got %b want 1", bus.empty); end
        n_checks++; if (bus.ld_hit !== 1'b0) begin n_fail++; $display("FAIL rst_ld_hit: got %b want 0", bus.ld_hit); end
        n_checks++; if (bus.ld_fwd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_fwd_valid: got %b want 0", bus.ld_fwd_valid); end
        @(negedge clock);
        reset = 1'b1;
        #1;
        n_checks++; if (bus.st_ready !== 1'b1) begin n_fail++; $display("FAIL idle_st_ready: got %b want 1", bus.st_ready); end
        n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL idle_empty: got %b want 1", bus.empty); end
        n_checks++; if (bus.mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL idle_req_valid: got %b want 0", bus.mem_req_valid); end
        cycle();
    endtask

    task automatic test_merge();
        bus.mem_req_ready = 1'b0;
        do_store(32'h1000, 32'hA);
        do_store(32'h2004, 32'hB);
        do_store(32'h2008, 32'hC);
        bus.mem_req_ready = 1'b1;
        #1;
        n_checks++; if (bus.mem_req_addr !== 32'h1000) begin n_fail++; $display("FAIL merge_req1_addr: got %h want 1000", bus.mem_req_addr); end
        n_checks++; if (bus.mem_req_mask !== 16'h000F) begin n_fail++; $display("FAIL merge_req1_mask: got %h want 000f", bus.mem_req_mask); end
        n_checks++; if (bus.mem_req_data[31:0] !== 32'hA) begin n_fail++; $display("FAIL merge_req1_data: got %h want a", bus.mem_req_data[31:0]); end
        cycle();
        #1;
        n_checks++; if (bus.mem_req_addr !== 32'h2000) begin n_fail++; $display("FAIL merge_req2_addr: got %h want 2000", bus.mem_req_addr); end
        n_checks++; if (bus.mem_req_mask !== 16'h0FF0) begin n_fail++; $display("FAIL merge_req2_mask: got %h want 0ff0", bus.mem_req_mask); end
        n_checks++; if (bus.mem_req_data[95:32] !== 64'h0000000C_0000000B) begin n_fail++; $display("FAIL merge_req2_data: got %h want c_b", bus.mem_req_data[95:32]); end
        cycle();
        #1;
        n_checks++; if (bus.mem_req_valid !== 1'b0 || bus.empty !== 1'b1) begin n_fail++; $display("FAIL merge_count2: valid=%b empty=%b want 0/1", bus.mem_req_valid, bus.empty); end
        bus.mem_req_ready = 1'b0;
    endtask

    task automatic test_head_no_merge();
        bus.mem_req_ready = 1'b0;
        do_store(32'h3000, 32'h1);
        do_store(32'h3004, 32'h2);
        bus.mem_req_ready = 1'b1;
        #1;
        n_checks++; if (bus.mem_req_mask !== 16'h000F || bus.mem_req_data[31:0] !== 32'h1) begin n_fail++; $display("FAIL head_req1: mask=%h data=%h want 000f/1", bus.mem_req_mask, bus.mem_req_data[31:0]); end
        cycle();
        #1;
        n_checks++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h3000) begin n_fail++; $display("FAIL head_req2_addr: valid=%b addr=%h want 1/3000", bus.mem_req_valid, bus.mem_req_addr); end
        n_checks++; if (bus.mem_req_mask !== 16'h00F0 || bus.mem_req_data[63:32] !== 32'h2) begin n_fail++; $display("FAIL head_req2: mask=%h data=%h want 00f0/2", bus.mem_req_mask, bus.mem_req_data[63:32]); end
        cycle();
        bus.mem_req_ready = 1'b0;
    endtask

    task automatic test_full();
        logic [31:0] exp_addr[4] = '{32'h200, 32'h300, 32'h400, 32'h500};
        bus.mem_req_ready = 1'b0;
        for (int i = 1; i <= DEPTH; i++) do_store(32'(i) << 8, 32'(i));
        #1;
        n_checks++; if (bus.st_ready !== 1'b0) begin n_fail++; $display("FAIL full_st_ready: got %b want 0", bus.st_ready); end
        bus.st_valid = 1'b1; bus.st_addr = 32'h500; bus.st_data = 32'h5;
        repeat (3) cycle();
        #1;
        n_checks++; if (bus.st_ready !== 1'b0 || bus.mem_req_addr !== 32'h100) begin n_fail++; $display("FAIL full_held: st_ready=%b head=%h want 0/100", bus.st_ready, bus.mem_req_addr); end
        bus.mem_req_ready = 1'b1;
        cycle();
        bus.mem_req_ready = 1'b0;
        #1;
        n_checks++; if (bus.st_ready !== 1'b1) begin n_fail++; $display("FAIL full_freed: st_ready=%b want 1", bus.st_ready); end
        cycle();
        bus.st_valid = 1'b0;
        bus.mem_req_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== exp_addr[i] || bus.mem_req_data[31:0] !== 32'(i + 2)) begin
                n_fail++;
                $display("FAIL full_order[%0d]: valid=%b addr=%h data=%h want 1/%h/%h", i, bus.mem_req_valid, bus.mem_req_addr, bus.mem_req_data[31:0], exp_addr[i], i + 2);
            end
            cycle();
        end
        bus.mem_req_ready = 1'b0;
    endtask

    task automatic test_ld_hit();
        bus.mem_req_ready = 1'b0;
        do_store(32'h1000, 32'h55);
        bus.ld_addr = 32'h100C; #1;
        n_checks++; if (bus.ld_hit !== 1'b1) begin n_fail++; $display("FAIL ld_hit_same_line: got %b want 1", bus.ld_hit); end
        n_checks++; if (bus.ld_fwd_valid !== 1'b0) begin n_fail++; $display("FAIL ld_fwd_partial: got %b want 0", bus.ld_fwd_valid); end
        bus.ld_addr = 32'h1010; #1;
        n_checks++; if (bus.ld_hit !== 1'b0) begin n_fail++; $display("FAIL ld_hit_next_line: got %b want 0", bus.ld_hit); end
        bus.ld_addr = 32'h1000; #1;
        n_checks++; if (bus.ld_fwd_valid !== FWD || bus.ld_fwd_data !== (FWD ? 32'h55 : 32'h0)) begin n_fail++; $display("FAIL ld_fwd_word0: valid=%b data=%h want %b", bus.ld_fwd_valid, bus.ld_fwd_data, FWD); end
        drain();
        bus.ld_addr = 32'h1000; #1;
        n_checks++; if (bus.ld_hit !== 1'b0) begin n_fail++; $display("FAIL ld_hit_after_drain: got %b want 0", bus.ld_hit); end
    endtask

    task automatic test_forward();
        bus.mem_req_ready = 1'b0;
        do_store(32'h40, 32'h11);
        do_store(32'h40, 32'h22);
        bus.ld_addr = 32'h40; #1;
        n_checks++; if (bus.ld_fwd_valid !== FWD || bus.ld_fwd_data !== (FWD ? 32'h22 : 32'h0)) begin n_fail++; $display("FAIL fwd_youngest: valid=%b data=%h want %b/%h", bus.ld_fwd_valid, bus.ld_fwd_data, FWD, FWD ? 32'h22 : 32'h0); end
        bus.ld_addr = 32'h44; #1;
        n_checks++; if (bus.ld_fwd_valid !== 1'b0 || bus.ld_hit !== 1'b1) begin n_fail++; $display("FAIL fwd_partial: valid=%b hit=%b want 0/1", bus.ld_fwd_valid, bus.ld_hit); end
        drain();
    endtask

    task automatic test_reset_mid_drain();
        bus.mem_req_ready = 1'b0;
        do_store(32'h7000, 32'h7);
        do_store(32'h8000, 32'h8);
        do_store(32'h9000, 32'h9);
        bus.mem_req_ready = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        n_checks++; if (bus.mem_req_valid !== 1'b0 || bus.empty !== 1'b1) begin n_fail++; $display("FAIL async_reset: valid=%b empty=%b want 0/1", bus.mem_req_valid, bus.empty); end
        n_checks++; if (bus.st_ready !== 1'b0) begin n_fail++; $display("FAIL async_reset_st_ready: got %b want 0", bus.st_ready); end
        model_q.delete();
        @(negedge clock);
        reset = 1'b1;
        bus.mem_req_ready = 1'b0;
        cycle();
        #1;
        n_checks++; if (bus.mem_req_valid !== 1'b0 || bus.empty !== 1'b1) begin n_fail++; $display("FAIL reset_discard: valid=%b empty=%b want 0/1", bus.mem_req_valid, bus.empty); end
    endtask

    task automatic test_random();
        logic        exp_hit, exp_fv;
        logic [31:0] exp_fd;
        logic [27:0] ll;
        int          lk;
        for (int c = 0; c < 400; c++) begin
            bus.st_valid = 1'($urandom_range(0, 1));
            bus.st_addr  = 32'h8000 + ($urandom_range(0, 2) << 4) + ($urandom_range(0, 3) << 2) + $urandom_range(0, 3);
            bus.st_data  = $urandom;
            bus.mem_req_ready = (c < 200) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 7);
            bus.ld_addr  = 32'h8000 + ($urandom_range(0, 3) << 4) + ($urandom_range(0, 3) << 2);
            #1;
            ll = bus.ld_addr[31:4];
            lk = int'(bus.ld_addr[3:2]);
            exp_hit = 1'b0;
            exp_fv  = 1'b0;
            exp_fd  = '0;
            foreach (model_q[i]) if (model_q[i].line == ll) exp_hit = 1'b1;
            for (int i = model_q.size() - 1; i >= 0; i--) begin
                if (model_q[i].line == ll) begin
                    if (FWD && (&model_q[i].mask[4*lk +: 4])) begin
                        exp_fv = 1'b1;
                        exp_fd = model_q[i].data[32*lk +: 32];
                    end
                    break;
                end
            end
            n_checks++; if (bus.st_ready !== (model_q.size() < DEPTH)) begin n_fail++; $display("FAIL rand_st_ready c=%0d: got %b want %b", c, bus.st_ready, model_q.size() < DEPTH); end
            n_checks++; if (bus.mem_req_valid !== (model_q.size() > 0) || bus.empty !== (model_q.size() == 0)) begin n_fail++; $display("FAIL rand_valid_empty c=%0d: valid=%b empty=%b size=%0d", c, bus.mem_req_valid, bus.empty, model_q.size()); end
            if (model_q.size() > 0) begin
                n_checks++;
                if (bus.mem_req_addr !== {model_q[0].line, 4'h0} || bus.mem_req_mask !== model_q[0].mask || bus.mem_req_data !== model_q[0].data) begin
                    n_fail++;
                    $display("FAIL rand_head c=%0d: addr=%h mask=%h data=%h want %h/%h/%h", c, bus.mem_req_addr, bus.mem_req_mask, bus.mem_req_data, {model_q[0].line, 4'h0}, model_q[0].mask, model_q[0].data);
                end
            end
            n_checks++; if (bus.ld_hit !== exp_hit) begin n_fail++; $display("FAIL rand_ld_hit c=%0d: got %b want %b", c, bus.ld_hit, exp_hit); end
            n_checks++; if (bus.ld_fwd_valid !== exp_fv || bus.ld_fwd_data !== exp_fd) begin n_fail++; $display("FAIL rand_fwd c=%0d: valid=%b data=%h want %b/%h", c, bus.ld_fwd_valid, bus.ld_fwd_data, exp_fv, exp_fd); end
            cycle();
        end
        bus.st_valid = 1'b0;
        drain();
    endtask

    initial begin
        bus.st_valid      = 1'b0;
        bus.st_addr       = '0;
        bus.st_data       = '0;
        bus.mem_req_ready = 1'b0;
        bus.ld_addr       = '0;
        test_reset();
        test_merge();
        test_head_no_merge();
        test_full();
        test_ld_hit();
        test_forward();
        test_reset_mid_drain();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
